// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, sub_bytes FSM encoding and byte index helper
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // MSB position of state byte s(r,c); byte s(0,0) sits at the top of the vector
  function automatic int unsigned byte_msb(input int unsigned r, input int unsigned c);
    return AES_STATE_W - 1 - AES_BYTE_W * (4 * c + r);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational FIPS-197 forward S-box, one byte in, one byte out
module aes_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] in_byte,
  output logic [AES_BYTE_W-1:0] out_byte
);

  // Entry 8'h00 is the most-significant byte of the table
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] bit_hi;

  always_comb begin
    bit_hi   = 11'd2047 - {in_byte, 3'b000};
    out_byte = SBOX_TABLE[bit_hi -: 8];
  end

endmodule

// File: rtl/sub_bytes_iter.sv
// rtl/sub_bytes_iter.sv - iterative AES SubBytes, BPC S-boxes walked over the state
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AES_STATE_W-1:0] state_sb_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [AES_STATE_W-1:0] state_sb_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int NSTEP   = 16 / BPC;
  localparam int SLICE_W = AES_BYTE_W * BPC;
  localparam int CW      = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
      $error("sub_bytes_iter: BPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  logic [1:0]             state;
  logic [CW-1:0]          step_cnt;
  logic [AES_STATE_W-1:0] work;
  logic [AES_STATE_W-1:0] work_next;
  logic [SLICE_W-1:0]     cur_slice;
  logic [SLICE_W-1:0]     sub_slice;

  // Slice k is selected by a compare per step so every part-select index stays constant
  always_comb begin
    cur_slice = '0;
    work_next = work;
    for (int k = 0; k < NSTEP; k++) begin
      if (step_cnt == CW'(k)) begin
        cur_slice                        = work[k*SLICE_W +: SLICE_W];
        work_next[k*SLICE_W +: SLICE_W]  = sub_slice;
      end
    end
  end

  genvar j;
  generate
    for (j = 0; j < BPC; j++) begin : g_sbox
      aes_sbox u_sbox (
        .in_byte  (cur_slice[j*AES_BYTE_W +: AES_BYTE_W]),
        .out_byte (sub_slice[j*AES_BYTE_W +: AES_BYTE_W])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      work     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work     <= state_sb_in;
            step_cnt <= '0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          work     <= work_next;
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == CW'(NSTEP - 1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = (state == ST_IDLE);
  assign out_valid    = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);
  assign state_sb_out = work;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb/tb_sub_bytes_iter.sv - bench for sub_bytes_iter at BPC=4, 1 and 16
module tb_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] din  [3];
  logic         ivld [3];
  logic         ordy [3];
  logic [127:0] dout [3];
  logic         irdy [3];
  logic         ovld [3];
  logic         bsy  [3];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int nstep_of [3] = '{4, 16, 1};

  always #5 clk = ~clk;

  sub_bytes_iter #(.BPC(4)) u_bpc4 (
    .clk(clk), .reset(reset), .state_sb_in(din[0]), .in_valid(ivld[0]), .in_ready(irdy[0]),
    .state_sb_out(dout[0]), .out_valid(ovld[0]), .out_ready(ordy[0]), .busy(bsy[0]));
  sub_bytes_iter #(.BPC(1)) u_bpc1 (
    .clk(clk), .reset(reset), .state_sb_in(din[1]), .in_valid(ivld[1]), .in_ready(irdy[1]),
    .state_sb_out(dout[1]), .out_valid(ovld[1]), .out_ready(ordy[1]), .busy(bsy[1]));
  sub_bytes_iter #(.BPC(16)) u_bpc16 (
    .clk(clk), .reset(reset), .state_sb_in(din[2]), .in_valid(ivld[2]), .in_ready(irdy[2]),
    .state_sb_out(dout[2]), .out_valid(ovld[2]), .out_ready(ordy[2]), .busy(bsy[2]));

  // Reference S-box from its definition: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    logic [7:0] r;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    if (a == 8'h00) inv = 8'h00;
    r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return r;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_ref(s[8*i +: 8]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      ivld[i] = 1'b0;
      ordy[i] = 1'b0;
      din[i]  = '0;
    end
  endtask

  // Accept one block, measure latency to out_valid, check result and release
  task automatic run_block(input int idx, input logic [127:0] d, input logic [127:0] exp_out,
                           input string tag);
    int lat = 0;
    total_cnt++;
    if (irdy[idx] !== 1'b1) $display("FAIL %s ready_before: in_ready=%b need 1", tag, irdy[idx]);
    else pass_cnt++;
    din[idx] = d; ivld[idx] = 1'b1; ordy[idx] = 1'b1;
    tick();
    ivld[idx] = 1'b0;
    while (ovld[idx] !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    total_cnt++;
    if (lat !== nstep_of[idx]) $display("FAIL %s latency: got %0d need %0d", tag, lat, nstep_of[idx]);
    else pass_cnt++;
    total_cnt++;
    if (dout[idx] !== exp_out) $display("FAIL %s data: got %h need %h", tag, dout[idx], exp_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ovld[idx] !== 1'b0 || bsy[idx] !== 1'b0 || irdy[idx] !== 1'b1)
      $display("FAIL %s release: out_valid=%b busy=%b in_ready=%b need 0 0 1",
               tag, ovld[idx], bsy[idx], irdy[idx]);
    else pass_cnt++;
    ordy[idx] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (irdy[i] !== 1'b1 || ovld[i] !== 1'b0 || bsy[i] !== 1'b0 || dout[i] !== 128'h0)
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b busy=%b out=%h need 1 0 0 0",
                 i, irdy[i], ovld[i], bsy[i], dout[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_fips_vector();
    int low = 0;
    din[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; ivld[0] = 1'b1; ordy[0] = 1'b1;
    tick();
    ivld[0] = 1'b0;
    while (irdy[0] !== 1'b1 && low < 100) begin
      if (ovld[0] === 1'b1) begin
        total_cnt++;
        if (dout[0] !== 128'hd42711aee0bf98f1b8b45de51e415230)
          $display("FAIL fips_data: got %h need d42711aee0bf98f1b8b45de51e415230", dout[0]);
        else pass_cnt++;
        total_cnt++;
        if (low !== 4) $display("FAIL fips_latency: got %0d need 4", low);
        else pass_cnt++;
      end
      tick();
      low++;
    end
    total_cnt++;
    if (low !== 5) $display("FAIL fips_ready_low: got %0d cycles need 5", low);
    else pass_cnt++;
    ordy[0] = 1'b0;
  endtask

  task automatic test_sbox_spot();
    for (int i = 0; i < 3; i++) begin
      run_block(i, {16{8'h00}}, {16{8'h63}}, $sformatf("spot00_%0d", i));
      run_block(i, {16{8'h53}}, {16{8'hed}}, $sformatf("spot53_%0d", i));
    end
  endtask

  task automatic test_random();
    logic [127:0] d;
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 4; n++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        run_block(i, d, sub_ref(d), $sformatf("rand_%0d_%0d", i, n));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] e = sub_ref(d);
    int wait_cnt = 0;
    din[0] = d; ivld[0] = 1'b1; ordy[0] = 1'b0;
    tick();
    ivld[0] = 1'b0;
    while (ovld[0] !== 1'b1 && wait_cnt < 100) begin
      tick();
      wait_cnt++;
    end
    ivld[0] = 1'b1;
    din[0] = ~d;
    for (int c = 0; c < 10; c++) begin
      total_cnt++;
      if (ovld[0] !== 1'b1 || dout[0] !== e || irdy[0] !== 1'b0)
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out=%h need 1 0 %h",
                 c, ovld[0], irdy[0], dout[0], e);
      else pass_cnt++;
      tick();
    end
    ivld[0] = 1'b0;
    ordy[0] = 1'b1;
    tick();
    total_cnt++;
    if (ovld[0] !== 1'b0 || bsy[0] !== 1'b0 || irdy[0] !== 1'b1)
      $display("FAIL bp_release: out_valid=%b busy=%b in_ready=%b need 0 0 1",
               ovld[0], bsy[0], irdy[0]);
    else pass_cnt++;
    ordy[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    din[0] = {$urandom, $urandom, $urandom, $urandom};
    ivld[0] = 1'b1; ordy[0] = 1'b1;
    tick();
    ivld[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total_cnt++;
    if (ovld[0] !== 1'b0 || bsy[0] !== 1'b0 || irdy[0] !== 1'b1 || dout[0] !== 128'h0)
      $display("FAIL reset_mid: out_valid=%b busy=%b in_ready=%b out=%h need 0 0 1 0",
               ovld[0], bsy[0], irdy[0], dout[0]);
    else pass_cnt++;
    ordy[0] = 1'b0;
    run_block(0, 128'h0, {16{8'h63}}, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [127:0] blk [2];
    logic [127:0] res [$];
    int acc [$];
    int cyc = 0;
    blk[0] = {$urandom, $urandom, $urandom, $urandom};
    blk[1] = {$urandom, $urandom, $urandom, $urandom};
    din[0] = blk[0]; ivld[0] = 1'b1; ordy[0] = 1'b1;
    while ((res.size() < 2) && cyc < 60) begin
      if (ovld[0] === 1'b1) res.push_back(dout[0]);
      if (irdy[0] === 1'b1 && ivld[0] === 1'b1) begin
        acc.push_back(cyc);
        if (acc.size() == 1) begin
          tick(); cyc++;
          din[0] = blk[1];
          continue;
        end else ivld[0] = 1'b1;
        tick(); cyc++;
        ivld[0] = 1'b0;
        continue;
      end
      tick(); cyc++;
    end
    ivld[0] = 1'b0; ordy[0] = 1'b0;
    total_cnt++;
    if (acc.size() != 2) $display("FAIL b2b_accepts: got %0d need 2", acc.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (acc[1] - acc[0] != nstep_of[0] + 2)
        $display("FAIL b2b_gap: got %0d need %0d", acc[1] - acc[0], nstep_of[0] + 2);
      else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (res.size() <= i) $display("FAIL b2b_result%0d: got none need %h", i, sub_ref(blk[i]));
      else if (res[i] !== sub_ref(blk[i]))
        $display("FAIL b2b_result%0d: got %h need %h", i, res[i], sub_ref(blk[i]));
      else pass_cnt++;
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_fips_vector();
    test_sbox_spot();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
